// File: rtl/apb_regfile_slave_if.sv
// APB completer-side bus bundle for apb_regfile_slave; the master modport drives
// the request, the slave modport returns the response.
interface apb_regfile_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  psel_i;
  logic                  penable_i;
  logic                  pwrite_i;
  logic [ADDR_WIDTH-1:0] paddr_i;
  logic [DATA_WIDTH-1:0] pwdata_i;
  logic [DATA_WIDTH-1:0] prdata_o;
  logic                  pready_o;
  logic                  pslverr_o;

  modport master (
    output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
    input  prdata_o, pready_o, pslverr_o
  );

  modport slave (
    input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
    output prdata_o, pready_o, pslverr_o
  );
endinterface

// File: rtl/apb_regfile_slave.sv
// APB register-file completer: ID/CTRL/STATUS/scratch registers, mailbox FIFO,
// programmable wait states and pslverr. Define APB_SLV_IRQ_EN for CTRL.IRQEN and irq_o.
//
// state  | meaning
// IDLE   | no transfer in progress, waiting for a setup phase
// ACCESS | access phase; cnt counts remaining wait states, completes at cnt==0
module apb_regfile_slave #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    FIFO_DEPTH_LG2 = 3,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE       = 32'hA9B0_0001,
  parameter logic [3:0]            RESET_WAIT     = 4'd0
) (
  input  logic                clk,
  input  logic                rst,
  apb_regfile_slave_if.slave  apb
`ifdef APB_SLV_IRQ_EN
  ,
  output logic                irq_o
`endif
);
  localparam int DEPTH = 2 ** FIFO_DEPTH_LG2;
  localparam logic [FIFO_DEPTH_LG2:0]   FULL_CNT = {1'b1, {FIFO_DEPTH_LG2{1'b0}}};
  localparam logic [FIFO_DEPTH_LG2:0]   CNT_ONE  = 1;
  localparam logic [FIFO_DEPTH_LG2-1:0] PTR_ONE  = 1;

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t                    state;
  logic [3:0]                cnt;
  logic [3:0]                ctrl_wait;
`ifdef APB_SLV_IRQ_EN
  logic                      ctrl_irqen;
`endif
  logic [DATA_WIDTH-1:0]     scratch [4];
  logic [DATA_WIDTH-1:0]     fifo_mem [DEPTH];
  logic [FIFO_DEPTH_LG2-1:0] rd_ptr;
  logic [FIFO_DEPTH_LG2-1:0] wr_ptr;
  logic [FIFO_DEPTH_LG2:0]   fifo_count;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic [9:0]            off;
  logic [DATA_WIDTH-1:0] rd_val;
  logic [DATA_WIDTH-1:0] ctrl_rd;
  logic [DATA_WIDTH-1:0] status_rd;
  logic                  acc_err;
  logic                  done;
  logic                  commit;
  logic                  unused_addr;

  assign fifo_full   = (fifo_count == FULL_CNT);
  assign fifo_empty  = (fifo_count == '0);
  assign off         = apb.paddr_i[11:2];
  assign unused_addr = ^{apb.paddr_i[ADDR_WIDTH-1:12], apb.paddr_i[1:0]};

  always_comb begin
    ctrl_rd        = '0;
    ctrl_rd[3:0]   = ctrl_wait;
`ifdef APB_SLV_IRQ_EN
    ctrl_rd[8]     = ctrl_irqen;
`endif
    status_rd                   = '0;
    status_rd[FIFO_DEPTH_LG2:0] = fifo_count;
    status_rd[16]               = fifo_full;
    status_rd[17]               = fifo_empty;
  end

  // Read value and error are decoded from pre-update register state.
  always_comb begin
    rd_val  = '0;
    acc_err = 1'b0;
    case (off)
      10'h000: if (apb.pwrite_i) acc_err = 1'b1; else rd_val = ID_VALUE;
      10'h001: rd_val = ctrl_rd;
      10'h002: if (apb.pwrite_i) acc_err = 1'b1; else rd_val = status_rd;
      10'h003: begin
        acc_err = apb.pwrite_i ? fifo_full : fifo_empty;
        rd_val  = fifo_mem[rd_ptr];
      end
      10'h004, 10'h005, 10'h006, 10'h007: rd_val = scratch[off[1:0]];
      default: acc_err = 1'b1;
    endcase
  end

  assign done          = (state == S_ACCESS) && (cnt == 4'd0) && apb.psel_i;
  assign commit        = done && !acc_err && !rst;
  assign apb.pready_o  = done;
  assign apb.pslverr_o = done && acc_err;
  assign apb.prdata_o  = (done && !apb.pwrite_i && !acc_err) ? rd_val : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      ctrl_wait  <= RESET_WAIT;
`ifdef APB_SLV_IRQ_EN
      ctrl_irqen <= 1'b0;
`endif
      for (int i = 0; i < 4; i++) scratch[i] <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (apb.psel_i && !apb.penable_i) begin
            state <= S_ACCESS;
            cnt   <= ctrl_wait;
          end
        end
        S_ACCESS: begin
          if (!apb.psel_i)        state <= S_IDLE;
          else if (cnt != 4'd0)   cnt   <= cnt - 4'd1;
          else                    state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (commit && apb.pwrite_i) begin
        case (off)
          10'h001: begin
            ctrl_wait  <= apb.pwdata_i[3:0];
`ifdef APB_SLV_IRQ_EN
            ctrl_irqen <= apb.pwdata_i[8];
`endif
          end
          10'h003: begin
            fifo_mem[wr_ptr] <= apb.pwdata_i;
            wr_ptr           <= wr_ptr + PTR_ONE;
            fifo_count       <= fifo_count + CNT_ONE;
          end
          10'h004, 10'h005, 10'h006, 10'h007: scratch[off[1:0]] <= apb.pwdata_i;
          default: ;
        endcase
      end

      if (commit && !apb.pwrite_i && off == 10'h003) begin
        rd_ptr     <= rd_ptr + PTR_ONE;
        fifo_count <= fifo_count - CNT_ONE;
      end
    end
  end

`ifdef APB_SLV_IRQ_EN
  always_ff @(posedge clk) begin
    if (rst) irq_o <= 1'b0;
    else     irq_o <= ctrl_irqen & ~fifo_empty;
  end
`endif
endmodule
